// File: rtl/bp_lce_req_queue_pkg.sv
// Shared types for the LCE request queue: cache request, metadata, BedRock header, queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_lce_req_queue_pkg;

    localparam int paddr_width_gp         = 40;
    localparam int lce_id_width_gp        = 4;
    localparam int cce_id_width_gp        = 4;
    localparam int way_id_width_gp        = 4;
    localparam int dword_width_gp         = 64;
    localparam int coh_noc_max_credits_gp = 8;

    typedef enum logic [1:0] {
        e_lce_mode_uncached = 2'd0,
        e_lce_mode_normal   = 2'd1,
        e_lce_mode_nonspec  = 2'd2
    } bp_lce_mode_e;

    typedef enum logic [3:0] {
        e_miss_load   = 4'd0,
        e_miss_store  = 4'd1,
        e_uc_load     = 4'd2,
        e_uc_store    = 4'd3,
        e_wt_store    = 4'd4,
        e_cache_flush = 4'd5,
        e_cache_clear = 4'd6
    } bp_cache_req_msg_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'b000,
        e_bedrock_msg_size_2   = 3'b001,
        e_bedrock_msg_size_4   = 3'b010,
        e_bedrock_msg_size_8   = 3'b011,
        e_bedrock_msg_size_16  = 3'b100,
        e_bedrock_msg_size_32  = 3'b101,
        e_bedrock_msg_size_64  = 3'b110,
        e_bedrock_msg_size_128 = 3'b111
    } bp_bedrock_msg_size_e;

    typedef enum logic [3:0] {
        e_bedrock_req_rd_miss = 4'd0,
        e_bedrock_req_wr_miss = 4'd1,
        e_bedrock_req_uc_rd   = 4'd2,
        e_bedrock_req_uc_wr   = 4'd3
    } bp_bedrock_req_type_e;

    typedef struct packed {
        bp_cache_req_msg_type_e      msg_type;
        logic [paddr_width_gp-1:0]   addr;
        bp_bedrock_msg_size_e        size;
        logic [dword_width_gp-1:0]   data;
    } bp_cache_req_s;

    typedef struct packed {
        logic [way_id_width_gp-1:0]  hit_or_repl_way;
    } bp_cache_req_metadata_s;

    typedef struct packed {
        bp_bedrock_req_type_e        msg_type;
        logic [paddr_width_gp-1:0]   addr;
        bp_bedrock_msg_size_e        size;
        logic [lce_id_width_gp-1:0]  src_id;
        logic [cce_id_width_gp-1:0]  dst_id;
        logic [way_id_width_gp-1:0]  lru_way_id;
        logic                        non_exclusive;
    } bp_lce_req_header_s;

    typedef struct packed {
        bp_cache_req_s               req;
        logic [way_id_width_gp-1:0]  way;
        logic                        md_v;
    } lce_req_entry_s;

    function automatic bp_bedrock_msg_size_e block_msg_size(input int block_width);
        case (block_width / 8)
            8:       return e_bedrock_msg_size_8;
            16:      return e_bedrock_msg_size_16;
            32:      return e_bedrock_msg_size_32;
            64:      return e_bedrock_msg_size_64;
            default: return e_bedrock_msg_size_128;
        endcase
    endfunction

endpackage

// File: rtl/bp_lce_req_credit_counter.sv
// Outstanding-request counter: +1 per accept, -1 per completion input (two may land together).
// Latency: full/empty reflect the registered count, one cycle after the update.
// Backpressure: none itself; full_o is used upstream to stall acceptance.
module bp_lce_req_credit_counter #(
    parameter int credits_p = 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic inc_i,
    input  logic dec_a_i,
    input  logic dec_b_i,
    output logic full_o,
    output logic empty_o
);
    localparam int cnt_width_lp = $clog2(credits_p + 1);
    localparam int sw_lp        = cnt_width_lp + 2;

    logic [cnt_width_lp-1:0] count_r;
    logic [sw_lp-1:0]        sum_up, sum_dn;

    assign sum_up = sw_lp'(count_r) + sw_lp'(inc_i);
    assign sum_dn = sw_lp'(dec_a_i) + sw_lp'(dec_b_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) count_r <= '0;
        else            count_r <= cnt_width_lp'(sum_up - sum_dn);
    end

    assign full_o  = (count_r == cnt_width_lp'(credits_p));
    assign empty_o = (count_r == '0);

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (sum_up >= sum_dn) else $error("bp_lce_req_credit_counter: underflow");
            assert (!(sum_up >= sum_dn && (sum_up - sum_dn) > sw_lp'(credits_p)))
                else $error("bp_lce_req_credit_counter: overflow");
        end
    end
`endif

endmodule

// File: rtl/bp_lce_req_queue.sv
// In-order LCE request queue: accepts miss/uc requests, binds late way metadata, issues BedRock headers.
// Latency: an entry can issue the cycle after it is enqueued with valid metadata.
// Backpressure: accept stalls on queue full, credits full or not ready; issue holds on lce_req_ready_and_i low.
module bp_lce_req_queue
    import bp_lce_req_queue_pkg::*;
#(
    parameter int assoc_p            = 8,
    parameter int sets_p             = 64,
    parameter int block_width_p      = 512,
    parameter int els_p              = 4,
    parameter int credits_p          = coh_noc_max_credits_gp,
    parameter int non_excl_reads_p   = 0,
    parameter int uc_data_width_p    = dword_width_gp,
    parameter int metadata_latency_p = 1,
    parameter int num_cce_p          = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [lce_id_width_gp-1:0]     lce_id_i,
    input  bp_lce_mode_e                   lce_mode_i,
    input  logic                           sync_done_i,
    output logic                           ready_o,
    input  bp_cache_req_s                  cache_req_i,
    input  logic                           cache_req_v_i,
    output logic                           cache_req_ready_and_o,
    input  bp_cache_req_metadata_s         cache_req_metadata_i,
    input  logic                           cache_req_metadata_v_i,
    input  logic                           cache_req_complete_i,
    input  logic                           uc_store_req_complete_i,
    output logic                           credits_full_o,
    output logic                           credits_empty_o,
    output bp_lce_req_header_s             lce_req_header_o,
    output logic [block_width_p-1:0]       lce_req_data_o,
    output logic                           lce_req_v_o,
    input  logic                           lce_req_ready_and_i
);
    localparam int lg_els_lp       = $clog2(els_p);
    localparam int block_bytes_lp  = block_width_p / 8;
    localparam int block_offset_lp = $clog2(block_bytes_lp);
    localparam int lg_cce_lp       = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;

    if (els_p < 2 || (els_p & (els_p - 1)) != 0 || metadata_latency_p > 1
        || uc_data_width_p < 64 || uc_data_width_p > dword_width_gp
        || (1 << way_id_width_gp) < assoc_p || sets_p < 1
        || block_width_p < 64 || block_width_p > 1024) begin : g_bad_params
        $error("bp_lce_req_queue: illegal parameterisation");
    end

    typedef enum logic {e_reset, e_ready} state_e;
    state_e state_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_reset;
        else            state_r <= e_ready;
    end

    assign ready_o = (state_r == e_ready) & ((lce_mode_i == e_lce_mode_uncached) | sync_done_i);

    lce_req_entry_s           mem_r [els_p];
    logic [lg_els_lp:0]       wptr_r, rptr_r;
    logic [lg_els_lp-1:0]     pend_idx_r;
    logic                     pend_v_r;
    logic                     queue_full, queue_empty;
    logic                     is_miss, is_uc, accept, enq, deq;
    logic                     md_bind_new, md_bind_old;
    lce_req_entry_s           head;

    assign queue_empty = (wptr_r == rptr_r);
    assign queue_full  = (wptr_r[lg_els_lp] != rptr_r[lg_els_lp])
                       && (wptr_r[lg_els_lp-1:0] == rptr_r[lg_els_lp-1:0]);

    assign is_miss = (cache_req_i.msg_type == e_miss_load) | (cache_req_i.msg_type == e_miss_store);
    assign is_uc   = (cache_req_i.msg_type == e_uc_load)   | (cache_req_i.msg_type == e_uc_store);

    assign cache_req_ready_and_o = ready_o & ~queue_full & ~credits_full_o;
    assign accept = cache_req_v_i & cache_req_ready_and_o;
    assign enq    = accept & (is_miss | is_uc);
    assign deq    = lce_req_v_o & lce_req_ready_and_i;

    // Zero-latency metadata belongs to the miss being accepted this cycle, not an older one.
    assign md_bind_new = cache_req_metadata_v_i & enq & is_miss & (metadata_latency_p == 0);
    assign md_bind_old = cache_req_metadata_v_i & pend_v_r & ~md_bind_new;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            pend_v_r   <= 1'b0;
            pend_idx_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + 1'b1;
            if (deq) rptr_r <= rptr_r + 1'b1;
            if (enq & is_miss & ~md_bind_new) begin
                pend_v_r   <= 1'b1;
                pend_idx_r <= wptr_r[lg_els_lp-1:0];
            end else if (md_bind_old) begin
                pend_v_r   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wptr_r[lg_els_lp-1:0]] <= '{req:  cache_req_i,
                                              way:  md_bind_new ? cache_req_metadata_i.hit_or_repl_way : '0,
                                              md_v: is_uc | md_bind_new};
        end
        if (md_bind_old) begin
            mem_r[pend_idx_r].way  <= cache_req_metadata_i.hit_or_repl_way;
            mem_r[pend_idx_r].md_v <= 1'b1;
        end
    end

    assign head        = mem_r[rptr_r[lg_els_lp-1:0]];
    assign lce_req_v_o = ~queue_empty & head.md_v;

    logic [cce_id_width_gp-1:0] dst_id;
    if (num_cce_p > 1) begin : g_cce_map
        assign dst_id = cce_id_width_gp'(head.req.addr[block_offset_lp +: lg_cce_lp]);
    end else begin : g_one_cce
        assign dst_id = '0;
    end

    always_comb begin
        lce_req_header_o            = '0;
        lce_req_data_o              = '0;
        lce_req_header_o.src_id     = lce_id_i;
        lce_req_header_o.dst_id     = dst_id;
        lce_req_header_o.lru_way_id = head.way;
        lce_req_header_o.addr       = head.req.addr;
        lce_req_header_o.size       = head.req.size;
        case (head.req.msg_type)
            e_miss_load, e_miss_store: begin
                lce_req_header_o.msg_type = (head.req.msg_type == e_miss_load)
                                          ? e_bedrock_req_rd_miss : e_bedrock_req_wr_miss;
                lce_req_header_o.addr     = head.req.addr & ~(paddr_width_gp'(block_bytes_lp - 1));
                lce_req_header_o.size     = block_msg_size(block_width_p);
                lce_req_header_o.non_exclusive = (head.req.msg_type == e_miss_load) & (non_excl_reads_p != 0);
            end
            e_uc_store: begin
                lce_req_header_o.msg_type = e_bedrock_req_uc_wr;
                lce_req_data_o[uc_data_width_p-1:0] = head.req.data[uc_data_width_p-1:0];
            end
            default: lce_req_header_o.msg_type = e_bedrock_req_uc_rd;
        endcase
    end

    bp_lce_req_credit_counter #(.credits_p(credits_p)) credits (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (enq),
        .dec_a_i   (cache_req_complete_i),
        .dec_b_i   (uc_store_req_complete_i),
        .full_o    (credits_full_o),
        .empty_o   (credits_empty_o)
    );

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(accept && !(is_miss || is_uc)))
                else $error("bp_lce_req_queue: unsupported request type dropped");
            assert (!(cache_req_metadata_v_i && !pend_v_r && !md_bind_new))
                else $error("bp_lce_req_queue: metadata with no pending miss");
        end
    end
`endif

endmodule
